// File: rtl/res_quant_packer_pkg.sv
// -----------------------------------------------------------------------------
// res_quant_packer_pkg
// Shared definitions for the result requantise/pack slice:
//   state_t     - burst sequencer states
//   bw()        - bits needed to hold the value n (never less than 1)
//   pack_beats()- input beats that fill one packed output word
//   SAT_W       - width of the saturated-lane counter
// -----------------------------------------------------------------------------
package res_quant_packer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SAT_W = 32;

    // Bits required to represent the unsigned value n; at least one bit.
    function automatic int bw(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Number of LANES-wide quantised beats packed into one OUT_W word.
    function automatic int pack_beats(input int out_w, input int lanes, input int data_w);
        return out_w / (lanes * data_w);
    endfunction

endpackage

// File: rtl/res_quant_packer_if.sv
// -----------------------------------------------------------------------------
// res_quant_packer_if
// Streaming bus of the packer: an input beat channel (in_valid/in_ready/in_data,
// LANES lanes of RES_W bits, lane i at [i*RES_W +: RES_W]) and a packed output
// channel (out_valid/out_ready/out_data/out_last).
//   master - producer of input beats / consumer of packed words
//   slave  - the packer itself
// -----------------------------------------------------------------------------
interface res_quant_packer_if #(
    parameter int LANES = 4,
    parameter int RES_W = 32,
    parameter int OUT_W = 256
);
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*RES_W-1:0]   in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [OUT_W-1:0]         out_data;
    logic                     out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/res_quant_packer_quant_lane.sv
// -----------------------------------------------------------------------------
// quant_lane
// Combinational requantiser for one lane: arithmetic right shift with
// round-half-up, then saturation to a signed DATA_W result.
//   x     in  RES_W   two's-complement accumulator value
//   shift in  SHIFT_W right-shift amount (already clamped to RES_W-1)
//   q     out DATA_W  quantised value
//   sat   out 1       high when q was clipped
// -----------------------------------------------------------------------------
module quant_lane #(
    parameter int RES_W   = 32,
    parameter int DATA_W  = 8,
    parameter int SHIFT_W = 6
) (
    input  logic [RES_W-1:0]   x,
    input  logic [SHIFT_W-1:0] shift,
    output logic [DATA_W-1:0]  q,
    output logic               sat
);

    logic [RES_W:0]        rnd_s;
    logic [RES_W:0]        sum_s;
    logic signed [RES_W:0] r_s;
    logic                  pos_ovf_s;
    logic                  neg_ovf_s;

    // Round, shift and clip; one extra bit keeps x + rounding term from wrapping.
    always_comb begin
        rnd_s     = {(RES_W+1){1'b0}};
        sum_s     = {(RES_W+1){1'b0}};
        r_s       = {(RES_W+1){1'b0}};
        pos_ovf_s = 1'b0;
        neg_ovf_s = 1'b0;
        q         = {DATA_W{1'b0}};
        sat       = 1'b0;

        if (shift != {SHIFT_W{1'b0}}) begin
            rnd_s = {{RES_W{1'b0}}, 1'b1} << (shift - {{(SHIFT_W-1){1'b0}}, 1'b1});
        end else begin
            rnd_s = {(RES_W+1){1'b0}};
        end

        sum_s = {x[RES_W-1], x} + rnd_s;
        r_s   = $signed(sum_s) >>> shift;

        // Result fits only if every bit above the DATA_W sign bit matches the sign.
        pos_ovf_s = !r_s[RES_W] && (r_s[RES_W-1:DATA_W-1] != {(RES_W-DATA_W+1){1'b0}});
        neg_ovf_s =  r_s[RES_W] && (r_s[RES_W-1:DATA_W-1] != {(RES_W-DATA_W+1){1'b1}});

        if (pos_ovf_s) begin
            q   = {1'b0, {(DATA_W-1){1'b1}}};
            sat = 1'b1;
        end else if (neg_ovf_s) begin
            q   = {1'b1, {(DATA_W-1){1'b0}}};
            sat = 1'b1;
        end else begin
            q   = r_s[DATA_W-1:0];
            sat = 1'b0;
        end
    end

endmodule

// File: rtl/res_quant_packer.sv
// -----------------------------------------------------------------------------
// res_quant_packer
// Requantises LANES-wide RES_W results to DATA_W, packs PACK accepted beats
// into one OUT_W word and emits burst_len words as a burst with out_last.
//   clk, rst   clock, synchronous active-low reset
//   start      one-cycle pulse in IDLE: latches shift (clamped) and burst_len
//   shift      arithmetic right-shift amount
//   burst_len  OUT_W words in the burst (0 -> done next cycle, no data)
//   bus        res_quant_packer_if.slave: input beats and packed words
//   done       one-cycle pulse after the final word handshake
//   sat_cnt    clipped-lane count for the current burst
// Optional feature macro: RES_QUANT_SAT_CNT_EN builds the sat_cnt counter;
// without it sat_cnt is tied to zero.
// -----------------------------------------------------------------------------
module res_quant_packer
    import res_quant_packer_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int RES_W   = 32,
    parameter int LANES   = 4,
    parameter int OUT_W   = 256,
    parameter int BURST_W = 16,
    parameter int SHIFT_W = bw(RES_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SHIFT_W-1:0] shift,
    input  logic [BURST_W-1:0] burst_len,
    res_quant_packer_if.slave  bus,
    output logic               done,
    output logic [SAT_W-1:0]   sat_cnt
);

    localparam int BEAT_W = LANES * DATA_W;
    localparam int PACK   = pack_beats(OUT_W, LANES, DATA_W);
    localparam int BCNT_W = bw(PACK - 1);
    localparam int LEFT_W = BURST_W + bw(PACK);

    localparam logic [BCNT_W-1:0]  LAST_BEAT = BCNT_W'(PACK - 1);
    localparam logic [BCNT_W-1:0]  BCNT_ONE  = {{(BCNT_W-1){1'b0}}, 1'b1};
    localparam logic [LEFT_W-1:0]  LEFT_ONE  = {{(LEFT_W-1){1'b0}}, 1'b1};
    localparam logic [BURST_W-1:0] WORD_ONE  = {{(BURST_W-1){1'b0}}, 1'b1};
    localparam logic [SHIFT_W-1:0] SHIFT_MAX = SHIFT_W'(RES_W - 1);

    if (OUT_W % (LANES * DATA_W) != 0) begin : g_bad_cfg
        $error("OUT_W must be a multiple of LANES*DATA_W");
    end

    state_t             state_r;
    logic [SHIFT_W-1:0] shift_r;
    logic [BURST_W-1:0] burst_len_r;
    logic [BCNT_W-1:0]  beat_cnt_r;
    logic [BURST_W-1:0] word_cnt_r;
    logic [LEFT_W-1:0]  beats_left_r;
    logic [OUT_W-1:0]   pack_buf_r;
    logic [OUT_W-1:0]   out_data_r;
    logic               out_valid_r;
    logic               out_last_r;
    logic               done_r;

    logic               in_ready_s;
    logic               accept_s;
    logic               out_hs_s;
    logic [SHIFT_W-1:0] shift_clamp_s;
    logic [BURST_W-1:0] wc_next_s;
    logic [BEAT_W-1:0]  beat_s;
    logic [LANES-1:0]   sat_flags_s;
    logic [OUT_W-1:0]   word_s;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        quant_lane #(
            .RES_W   (RES_W),
            .DATA_W  (DATA_W),
            .SHIFT_W (SHIFT_W)
        ) u_quant_lane (
            .x     (bus.in_data[i*RES_W +: RES_W]),
            .shift (shift_r),
            .q     (beat_s[i*DATA_W +: DATA_W]),
            .sat   (sat_flags_s[i])
        );
    end

    // Handshake qualifiers; the final beat of a word stalls only while the
    // previous word is still pending and not being taken this cycle.
    always_comb begin
        in_ready_s = 1'b0;
        accept_s   = 1'b0;
        out_hs_s   = 1'b0;
        wc_next_s  = word_cnt_r;
        if ((state_r == RUN) && (beats_left_r != {LEFT_W{1'b0}}) &&
            !((beat_cnt_r == LAST_BEAT) && out_valid_r && !bus.out_ready)) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
        accept_s = bus.in_valid && in_ready_s;
        out_hs_s = out_valid_r && bus.out_ready;
        if (out_hs_s) begin
            wc_next_s = word_cnt_r + WORD_ONE;
        end else begin
            wc_next_s = word_cnt_r;
        end
    end

    // Clamp the requested shift and assemble the completed word.
    always_comb begin
        shift_clamp_s = shift;
        word_s        = pack_buf_r;
        if (shift > SHIFT_MAX) begin
            shift_clamp_s = SHIFT_MAX;
        end else begin
            shift_clamp_s = shift;
        end
        word_s[(PACK-1)*BEAT_W +: BEAT_W] = beat_s;
    end

    // Burst sequencer, packing datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= IDLE;
            shift_r      <= {SHIFT_W{1'b0}};
            burst_len_r  <= {BURST_W{1'b0}};
            beat_cnt_r   <= {BCNT_W{1'b0}};
            word_cnt_r   <= {BURST_W{1'b0}};
            beats_left_r <= {LEFT_W{1'b0}};
            pack_buf_r   <= {OUT_W{1'b0}};
            out_data_r   <= {OUT_W{1'b0}};
            out_valid_r  <= 1'b0;
            out_last_r   <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        shift_r      <= shift_clamp_s;
                        burst_len_r  <= burst_len;
                        beat_cnt_r   <= {BCNT_W{1'b0}};
                        word_cnt_r   <= {BURST_W{1'b0}};
                        beats_left_r <= LEFT_W'(burst_len) * LEFT_W'(PACK);
                        out_last_r   <= 1'b0;
                        if (burst_len == {BURST_W{1'b0}}) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (out_hs_s) begin
                        word_cnt_r <= wc_next_s;
                    end
                    if (accept_s) begin
                        beats_left_r <= beats_left_r - LEFT_ONE;
                        if (beat_cnt_r == LAST_BEAT) begin
                            beat_cnt_r <= {BCNT_W{1'b0}};
                        end else begin
                            beat_cnt_r <= beat_cnt_r + BCNT_ONE;
                            pack_buf_r[int'(beat_cnt_r)*BEAT_W +: BEAT_W] <= beat_s;
                        end
                    end
                    // A new word may load in the same cycle the old one leaves.
                    if (accept_s && (beat_cnt_r == LAST_BEAT)) begin
                        out_data_r  <= word_s;
                        out_valid_r <= 1'b1;
                        out_last_r  <= (wc_next_s == (burst_len_r - WORD_ONE));
                    end else if (out_hs_s) begin
                        out_valid_r <= 1'b0;
                        out_last_r  <= 1'b0;
                    end
                    if (out_hs_s && out_last_r) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_last  = out_last_r;
    assign done          = done_r;

`ifdef RES_QUANT_SAT_CNT_EN
    localparam int SUM_W = bw(LANES);

    logic [SAT_W-1:0] sat_cnt_r;
    logic [SUM_W-1:0] beat_sat_s;
    logic [SAT_W:0]   sat_sum_s;

    // Clipped lanes in the current beat, added with a carry bit for saturation.
    always_comb begin
        beat_sat_s = {SUM_W{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            beat_sat_s = beat_sat_s + {{(SUM_W-1){1'b0}}, sat_flags_s[i]};
        end
        sat_sum_s = {1'b0, sat_cnt_r} + {{(SAT_W+1-SUM_W){1'b0}}, beat_sat_s};
    end

    // Per-burst clipped-lane counter, sticky at all-ones.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sat_cnt_r <= {SAT_W{1'b0}};
        end else if ((state_r == IDLE) && start) begin
            sat_cnt_r <= {SAT_W{1'b0}};
        end else if (accept_s) begin
            sat_cnt_r <= sat_sum_s[SAT_W] ? {SAT_W{1'b1}} : sat_sum_s[SAT_W-1:0];
        end else begin
            sat_cnt_r <= sat_cnt_r;
        end
    end

    assign sat_cnt = sat_cnt_r;
`else
    logic unused_sat_s;
    assign unused_sat_s = ^sat_flags_s;
    assign sat_cnt      = {SAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_res_quant_packer.sv
// -----------------------------------------------------------------------------
// tb_res_quant_packer
// Random and directed bursts against an arithmetic reference of the
// requantise/pack behaviour; checks data, out_last, in_ready, done and sat_cnt.
// -----------------------------------------------------------------------------
module tb_res_quant_packer;
    import res_quant_packer_pkg::*;

    localparam int DATA_W  = 8;
    localparam int RES_W   = 32;
    localparam int LANES   = 4;
    localparam int OUT_W   = 256;
    localparam int BURST_W = 16;
    localparam int SHIFT_W = bw(RES_W);
    localparam int BEAT_W  = LANES * DATA_W;
    localparam int PACK    = OUT_W / BEAT_W;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic [SHIFT_W-1:0] shift = '0;
    logic [BURST_W-1:0] burst_len = '0;
    logic               done;
    logic [31:0]        sat_cnt;

    int check_cnt = 0;
    int error_cnt = 0;

    logic [LANES*RES_W-1:0] dir_beats[$];
    logic [OUT_W-1:0]       first_word;

    res_quant_packer_if #(.LANES(LANES), .RES_W(RES_W), .OUT_W(OUT_W)) bus ();

    res_quant_packer #(
        .DATA_W(DATA_W), .RES_W(RES_W), .LANES(LANES),
        .OUT_W(OUT_W), .BURST_W(BURST_W), .SHIFT_W(SHIFT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .shift     (shift),
        .burst_len (burst_len),
        .bus       (bus),
        .done      (done),
        .sat_cnt   (sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
        check_cnt++;
        if (got !== exp) begin
            error_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference requantiser: plain integer round-half-up, shift, clip.
    function automatic logic [7:0] q_ref(input logic [31:0] x, input int sh, output bit sat);
        longint v;
        longint r;
        v = longint'($signed(x));
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
        r = v >>> sh;
        sat = 1'b0;
        if (r > 127) begin
            sat = 1'b1;
            r = 127;
        end else if (r < -128) begin
            sat = 1'b1;
            r = -128;
        end
        return r[7:0];
    endfunction

    function automatic logic [31:0] rand_lane();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 2))
            0: return r;
            1: return {{16{r[15]}}, r[15:0]};
            default: return {{22{r[9]}}, r[9:0]};
        endcase
    endfunction

    task automatic run_burst(input int blen, input int sh, input int rdy_pct, input int vld_pct,
                             input int stall_cyc, input bit poke, input bit thru);
        logic [OUT_W-1:0]       exp_q[$];
        logic [OUT_W-1:0]       buf_m = '0;
        logic [OUT_W-1:0]       w;
        logic [OUT_W-1:0]       prev_data = '0;
        logic [LANES*RES_W-1:0] cur = '0;
        logic [7:0]             q;
        logic [31:0]            sat_m = 0;
        int  total = blen * PACK;
        int  sh_eff = (sh > RES_W - 1) ? RES_W - 1 : sh;
        int  nbeat = 0, acc_n = 0, words_seen = 0, stalled = 0, cyc = 0;
        int  first_acc = -1, last_acc = -1;
        bit  have = 0, finished = 0, last_hs = 0, prev_stall = 0, saw_block = 0;
        bit  acc, ohs, satf, exp_rdy;

        start = 1'b1;
        shift = SHIFT_W'(sh);
        burst_len = BURST_W'(blen);
        @(posedge clk); #1;
        start = 1'b0;
        while (!finished && cyc < 4000) begin
            if (!have && acc_n < total && $urandom_range(1, 100) <= vld_pct) begin
                if (dir_beats.size() != 0) cur = dir_beats.pop_front();
                else for (int l = 0; l < LANES; l++) cur[l*RES_W +: RES_W] = rand_lane();
                have = 1;
            end
            bus.in_valid = have;
            bus.in_data  = cur;
            if (words_seen == 0 && stalled < stall_cyc) bus.out_ready = 1'b0;
            else bus.out_ready = ($urandom_range(1, 100) <= rdy_pct);
            start = poke && (cyc == 3);
            if (poke && cyc == 3) begin
                shift = '0;
                burst_len = 16'd1;
            end
            @(negedge clk);
            if (last_hs) begin
                check_eq("done_pulse", done, 1);
                check_eq("rdy_after", bus.in_ready, 0);
                check_eq("vld_after", bus.out_valid, 0);
                finished = 1;
            end else begin
                check_eq("done_early", done, 0);
                check_eq("out_valid", bus.out_valid, exp_q.size() != 0);
                exp_rdy = (acc_n < total) && !(nbeat == PACK - 1 && exp_q.size() != 0 && !bus.out_ready);
                check_eq("in_ready", bus.in_ready, exp_rdy);
                if (!bus.in_ready && acc_n < total) saw_block = 1;
                if (prev_stall) check_eq("hold", bus.out_data, prev_data);
                if (exp_q.size() != 0) check_eq("out_last", bus.out_last, words_seen == blen - 1);
                if (bus.out_valid && !bus.out_ready && words_seen == 0) stalled++;
                acc = bus.in_valid && bus.in_ready;
                ohs = bus.out_valid && bus.out_ready;
                if (ohs) begin
                    if (exp_q.size() == 0) begin
                        check_eq("spurious", 1, 0);
                    end else begin
                        w = exp_q.pop_front();
                        check_eq("data", bus.out_data, w);
                    end
                    if (words_seen == 0) first_word = bus.out_data;
                    words_seen++;
                    if (words_seen == blen) last_hs = 1;
                end
                if (acc) begin
                    for (int l = 0; l < LANES; l++) begin
                        q = q_ref(cur[l*RES_W +: RES_W], sh_eff, satf);
                        buf_m[nbeat*BEAT_W + l*DATA_W +: DATA_W] = q;
                        if (satf) sat_m++;
                    end
                    if (first_acc < 0) first_acc = cyc;
                    last_acc = cyc;
                    nbeat++;
                    acc_n++;
                    have = 0;
                    if (nbeat == PACK) begin
                        exp_q.push_back(buf_m);
                        nbeat = 0;
                    end
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_data  = bus.out_data;
            end
            cyc++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        bus.in_valid = 1'b0;
        if (!finished) check_eq("timeout", 0, 1);
        @(negedge clk);
        check_eq("done_once", done, 0);
        check_eq("rdy_idle", bus.in_ready, 0);
        check_eq("words", words_seen, blen);
        check_eq("leftover", exp_q.size(), 0);
`ifdef RES_QUANT_SAT_CNT_EN
        check_eq("sat_cnt", sat_cnt, sat_m);
`else
        check_eq("sat_cnt", sat_cnt, 0);
`endif
        if (thru) check_eq("thru", last_acc - first_acc + 1, total);
        if (stall_cyc > 0) check_eq("bp_block", saw_block, 1);
        @(posedge clk); #1;
    endtask

    task automatic zero_burst();
        start = 1'b1;
        shift = 6'd3;
        burst_len = 16'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check_eq("z_done", done, 1);
        check_eq("z_vld", bus.out_valid, 0);
        check_eq("z_rdy", bus.in_ready, 0);
        check_eq("z_sat_clr", sat_cnt, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("z_done_off", done, 0);
        check_eq("z_vld2", bus.out_valid, 0);
        @(posedge clk); #1;
    endtask

    task automatic reset_mid_burst();
        start = 1'b1;
        shift = 6'd2;
        burst_len = 16'd2;
        @(posedge clk); #1;
        start = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            check_eq("mid_rdy", bus.in_ready, 1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rst_rdy", bus.in_ready, 0);
        check_eq("rst_vld", bus.out_valid, 0);
        check_eq("rst_last", bus.out_last, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_sat", sat_cnt, 0);
        check_eq("rst_data", bus.out_data, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rst_idle", bus.in_ready, 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        logic [LANES*RES_W-1:0] b;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("r_rdy", bus.in_ready, 0);
        check_eq("r_vld", bus.out_valid, 0);
        check_eq("r_last", bus.out_last, 0);
        check_eq("r_done", done, 0);
        check_eq("r_sat", sat_cnt, 0);
        check_eq("r_data", bus.out_data, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Rounding points at shift=8
        b = {32'h0000_0080, 32'h0000_007F, 32'hFFFF_FE80, 32'h0000_0180};
        dir_beats.push_back(b);
        run_burst(1, 8, 100, 100, 0, 0, 0);
        check_eq("tp_round", first_word[31:0], 32'h0100_FF02);

        // Saturation both ways at shift=4
        b = {32'h0000_0000, 32'h0000_0000, 32'hFFFE_EE90, 32'h0001_0000};
        dir_beats.push_back(b);
        for (int i = 1; i < PACK; i++) dir_beats.push_back('0);
        run_burst(1, 4, 100, 100, 0, 0, 0);
        check_eq("tp_sat", first_word[31:0], 32'h0000_807F);
`ifdef RES_QUANT_SAT_CNT_EN
        check_eq("tp_sat_cnt", sat_cnt, 2);
`endif

        // Shift 0 pass-through with negative clip
        b = {32'h0000_007F, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFE_EE90};
        dir_beats.push_back(b);
        for (int i = 1; i < PACK; i++) dir_beats.push_back('0);
        run_burst(1, 0, 100, 100, 0, 0, 0);
        check_eq("tp_sh0", first_word[31:0], 32'h7FFD_0580);

        zero_burst();
        run_burst(3, 8, 100, 100, 0, 0, 1);
        run_burst(3, 6, 100, 100, 10, 0, 0);
        run_burst(2, 40, 70, 80, 0, 0, 0);
        run_burst(2, 5, 80, 90, 0, 1, 0);
        for (int i = 0; i < 4; i++)
            run_burst($urandom_range(1, 3), $urandom_range(0, 35), $urandom_range(40, 100),
                      $urandom_range(40, 100), 0, 0, 0);
        reset_mid_burst();
        run_burst(1, 3, 100, 100, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
        $finish;
    end

endmodule
